// File: rtl/fb_ctrl_pkg.sv
// rtl/fb_ctrl_pkg.sv - shared types and default sizes for the framebuffer write arbiter
package fb_ctrl_pkg;

    localparam int FB_ADDR_W = 9;
    localparam int FB_DATA_W = 24;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way write arbiter, round-robin by default
// FB_ARB_FIXED_PRIORITY_EN: requester A always wins ties and no last pointer is kept
module rr_arbiter2
    import fb_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

`ifdef FB_ARB_FIXED_PRIORITY_EN

    always_comb begin
        grant        = 2'b00;
        grant[REQ_A] = enable && valid[REQ_A];
        grant[REQ_B] = enable && valid[REQ_B] && !valid[REQ_A];
    end

`else

    req_id_t last;
    logic    tie;

    assign tie = valid[REQ_A] && valid[REQ_B];

    always_comb begin
        grant        = 2'b00;
        grant[REQ_A] = enable && valid[REQ_A] && (!valid[REQ_B] || last == REQ_B);
        grant[REQ_B] = enable && valid[REQ_B] && (!valid[REQ_A] || last == REQ_A);
    end

    // The pointer only moves when a tie was actually resolved.
    always_ff @(posedge clock) begin
        if (reset) begin
            last <= REQ_B;
        end else if (enable && tie) begin
            last <= (last == REQ_B) ? REQ_A : REQ_B;
        end
    end

`endif

endmodule

// File: rtl/framebuffer_write_arbiter.sv
// rtl/framebuffer_write_arbiter.sv - shares the pixel memory write port between two requesters and a clear engine
module framebuffer_write_arbiter
    import fb_ctrl_pkg::*;
#(
    parameter int A = FB_ADDR_W,
    parameter int S = FB_DATA_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear_req,
    input  logic [S-1:0] clear_color,
    output logic         clear_busy,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [A-1:0] a_address,
    input  logic [S-1:0] a_data,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [A-1:0] b_address,
    input  logic [S-1:0] b_data,
    output logic [A-1:0] mem_address,
    output logic [S-1:0] mem_data,
    output logic         mem_wren
);

    localparam logic [A-1:0] CNT_LAST = {A{1'b1}};

    fb_state_t    state;
    fb_state_t    state_next;
    logic [A-1:0] counter;
    logic [S-1:0] color;
    logic         arb_enable;
    logic [1:0]   grant;

    assign arb_enable = (state == ST_IDLE) && !clear_req;

    rr_arbiter2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .enable (arb_enable),
        .valid  ({b_valid, a_valid}),
        .grant  (grant)
    );

    assign a_ready = grant[REQ_A];
    assign b_ready = grant[REQ_B];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (clear_req) state_next = ST_CLEAR;
            ST_CLEAR: if (counter == CNT_LAST) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Address 0 is written straight from the accepting cycle, so counter holds the next address
    // and the 2^A writes line up exactly with clear_busy.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_wren    <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            clear_busy  <= 1'b0;
            counter     <= '0;
            color       <= '0;
        end else begin
            mem_wren <= 1'b0;
            case (state)
                ST_IDLE: begin
                    clear_busy <= 1'b0;
                    if (clear_req) begin
                        clear_busy  <= 1'b1;
                        color       <= clear_color;
                        counter     <= A'(1);
                        mem_wren    <= 1'b1;
                        mem_address <= '0;
                        mem_data    <= clear_color;
                    end else if (a_valid && a_ready) begin
                        mem_wren    <= 1'b1;
                        mem_address <= a_address;
                        mem_data    <= a_data;
                    end else if (b_valid && b_ready) begin
                        mem_wren    <= 1'b1;
                        mem_address <= b_address;
                        mem_data    <= b_data;
                    end
                end
                ST_CLEAR: begin
                    clear_busy  <= 1'b1;
                    mem_wren    <= 1'b1;
                    mem_address <= counter;
                    mem_data    <= color;
                    counter     <= counter + 1'b1;
                end
                default: clear_busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
// tb/tb_framebuffer_write_arbiter.sv - directed bench for framebuffer_write_arbiter (honours FB_ARB_FIXED_PRIORITY_EN)
module tb_framebuffer_write_arbiter;

    localparam int A = 9;
    localparam int S = 24;
    localparam int DEPTH = 1 << A;

    logic         clock = 1'b0;
    logic         reset;
    logic         clear_req;
    logic [S-1:0] clear_color;
    logic         clear_busy;
    logic         a_valid, a_ready, b_valid, b_ready;
    logic [A-1:0] a_address, b_address, mem_address;
    logic [S-1:0] a_data, b_data, mem_data;
    logic         mem_wren;

    int vectors = 0;
    int miscompares = 0;

    framebuffer_write_arbiter #(.A(A), .S(S)) dut (
        .clock       (clock),
        .reset       (reset),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_address   (a_address),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_address   (b_address),
        .b_data      (b_data),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_clear_write(input string tag, input int idx, input logic [S-1:0] col);
        check(tag, {29'd0, clear_busy, mem_wren, mem_address, mem_data},
              {29'd0, 1'b1, 1'b1, 9'(idx), col});
    endtask

    initial begin
        logic exp_a;

        reset = 1'b1; clear_req = 1'b0; clear_color = '0;
        a_valid = 1'b0; a_address = '0; a_data = '0;
        b_valid = 1'b0; b_address = '0; b_data = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("reset_wren", 64'(mem_wren), 64'd0);
        check("reset_addr", 64'(mem_address), 64'd0);
        check("reset_data", 64'(mem_data), 64'd0);
        check("reset_busy", 64'(clear_busy), 64'd0);
        check("reset_ready", {62'd0, a_ready, b_ready}, 64'd0);

        // single A write, one-cycle latency, then hold
        a_valid = 1'b1; a_address = 9'd5; a_data = 24'hFF0000;
        #1;
        check("a_only_ready", {62'd0, a_ready, b_ready}, 64'b10);
        tick();
        a_valid = 1'b0;
        check("a_only_write", {31'd0, mem_wren, mem_address, mem_data}, {31'd0, 1'b1, 9'd5, 24'hFF0000});
        tick();
        check("a_only_after", {31'd0, mem_wren, mem_address, mem_data}, {31'd0, 1'b0, 9'd5, 24'hFF0000});

        // tie for four cycles
        reset = 1'b1; tick(); reset = 1'b0;
        a_valid = 1'b1; a_address = 9'd10; a_data = 24'h000111;
        b_valid = 1'b1; b_address = 9'd20; b_data = 24'h000222;
        for (int i = 0; i < 4; i++) begin
`ifdef FB_ARB_FIXED_PRIORITY_EN
            exp_a = 1'b1;
`else
            exp_a = (i % 2 == 0);
`endif
            #1;
            check("tie_ready", {62'd0, a_ready, b_ready}, {62'd0, exp_a, ~exp_a});
            tick();
            if (i == 3) begin
                a_valid = 1'b0; b_valid = 1'b0;
            end
            check("tie_write", {31'd0, mem_wren, mem_address, mem_data},
                  {31'd0, 1'b1, exp_a ? {9'd10, 24'h000111} : {9'd20, 24'h000222}});
        end
        tick();
        check("tie_idle", 64'(mem_wren), 64'd0);

        // full clear beats a pending A request
        a_valid = 1'b1; a_address = 9'd7; a_data = 24'h777777;
        clear_req = 1'b1; clear_color = 24'h00FF00;
        #1;
        check("clear_blocks_ready", {62'd0, a_ready, b_ready}, 64'd0);
        tick();
        clear_req = 1'b0; a_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check_clear_write("clear_sweep", i, 24'h00FF00);
            tick();
        end
        check("clear_end", {62'd0, clear_busy, mem_wren}, 64'd0);
        tick();
        check("clear_end2", {62'd0, clear_busy, mem_wren}, 64'd0);

        // clear_req mid-sweep and in the last CLEAR cycle is ignored
        clear_req = 1'b1; clear_color = 24'h0000FF;
        tick();
        clear_req = 1'b0; clear_color = 24'hABCDEF;
        for (int i = 0; i < DEPTH; i++) begin
            check_clear_write("reclear_sweep", i, 24'h0000FF);
            clear_req = (i == 100 || i == 510);
            tick();
        end
        clear_req = 1'b0;
        check("reclear_end", {62'd0, clear_busy, mem_wren}, 64'd0);

        // reset aborts a sweep, then A is served first
        clear_req = 1'b1; clear_color = 24'h123456;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i <= 200; i++) begin
            if (i == 0 || i == 200) check_clear_write("abort_sweep", i, 24'h123456);
            if (i < 200) tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_wren", 64'(mem_wren), 64'd0);
        check("abort_busy", 64'(clear_busy), 64'd0);
        a_valid = 1'b1; a_address = 9'd40; a_data = 24'h404040;
        b_valid = 1'b1; b_address = 9'd41; b_data = 24'h414141;
        #1;
        check("abort_then_ready", {62'd0, a_ready, b_ready}, 64'b10);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("abort_then_write", {31'd0, mem_wren, mem_address, mem_data}, {31'd0, 1'b1, 9'd40, 24'h404040});
        tick();

        // B withdraws while A holds the port
        reset = 1'b1; tick(); reset = 1'b0;
        a_valid = 1'b1; a_address = 9'd50; a_data = 24'h050505;
        b_valid = 1'b1; b_address = 9'd60; b_data = 24'h060606;
        #1;
        check("withdraw_ready0", {62'd0, a_ready, b_ready}, 64'b10);
        tick();
        b_valid = 1'b0; a_address = 9'd51; a_data = 24'h515151;
        #1;
        check("withdraw_write0", {31'd0, mem_wren, mem_address, mem_data}, {31'd0, 1'b1, 9'd50, 24'h050505});
        check("withdraw_ready1", {62'd0, a_ready, b_ready}, 64'b10);
        tick();
        a_valid = 1'b0;
        check("withdraw_write1", {31'd0, mem_wren, mem_address, mem_data}, {31'd0, 1'b1, 9'd51, 24'h515151});
        tick();
        check("withdraw_idle0", {31'd0, mem_wren, mem_address, mem_data}, {31'd0, 1'b0, 9'd51, 24'h515151});
        tick();
        check("withdraw_idle1", 64'(mem_wren), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
